// File: rtl/joystick_debounce.sv
// ============================================================================
//  Module      : joystick_debounce
//  Description : Input stage for active-low DB9 joystick switches. Each pin is
//                synchronised with two flops into the i_clk50 domain, then
//                debounced by a per-bit stability counter that only advances
//                on a shared sample tick. Produces the clean active-high
//                state plus registered one-cycle press/release strobes.
//                Optional build macro JOY_SOCD_CLEAN_EN masks opposing
//                directions (up+down, left+right) to released in o_joy.
//                Bit map: [0]=up [1]=down [2]=left [3]=right [4]=fire.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module joystick_debounce #(
  parameter int N_INPUTS   = 5,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic                i_clk50,
  input  logic                i_rst,
  input  logic [N_INPUTS-1:0] i_joy_n,
  output logic [N_INPUTS-1:0] o_joy,
  output logic [N_INPUTS-1:0] o_press,
  output logic [N_INPUTS-1:0] o_release,
  output logic                o_changed,
  output logic                o_tick
);

  localparam int c_presc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_cnt_w   = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [c_presc_w-1:0] c_tick_max = c_presc_w'(TICK_DIV - 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_max  = c_cnt_w'(STABLE_CNT - 1);

  logic [N_INPUTS-1:0]              r_sync1;
  logic [N_INPUTS-1:0]              r_sync2;
  logic [N_INPUTS-1:0]              w_sample;
  logic [c_presc_w-1:0]             r_presc;
  logic                             w_tick;
  logic [N_INPUTS-1:0][c_cnt_w-1:0] r_cnt;
  logic [N_INPUTS-1:0][c_cnt_w-1:0] w_cnt_next;
  logic [N_INPUTS-1:0]              r_deb;
  logic [N_INPUTS-1:0]              w_deb_next;
  logic [N_INPUTS-1:0]              w_joy_next;
  logic [N_INPUTS-1:0]              r_joy;
  logic [N_INPUTS-1:0]              r_press;
  logic [N_INPUTS-1:0]              r_release;

  // Two-flop synchroniser; resets to the released (high) pin level.
  always_ff @(posedge i_clk50 or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= i_joy_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = ~r_sync2;

  // Free-running prescaler producing one tick every TICK_DIV clocks.
  always_ff @(posedge i_clk50 or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick = (r_presc == c_tick_max);

  // Per-bit stability counter: a change is accepted only after STABLE_CNT
  // consecutive ticks that all disagree with the current debounced level.
  always_comb begin
    w_deb_next = r_deb;
    w_cnt_next = r_cnt;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (w_tick) begin
        if (w_sample[i] == r_deb[i]) begin
          w_cnt_next[i] = '0;
        end else if (r_cnt[i] == c_cnt_max) begin
          w_deb_next[i] = w_sample[i];
          w_cnt_next[i] = '0;
        end else begin
          w_cnt_next[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef JOY_SOCD_CLEAN_EN
  // Opposing directions held together are both reported as released.
  // Requires N_INPUTS >= 4 (directions occupy bits 3:0).
  always_comb begin
    w_joy_next = w_deb_next;
    if (w_deb_next[0] && w_deb_next[1]) w_joy_next[1:0] = 2'b00;
    if (w_deb_next[2] && w_deb_next[3]) w_joy_next[3:2] = 2'b00;
  end
`else
  // Without cleaning the visible state is the raw debounced state.
  always_comb begin
    w_joy_next = w_deb_next;
  end
`endif

  // State registers; strobes come from comparing the next visible state with
  // the current one, so they are high for exactly the cycle after acceptance.
  always_ff @(posedge i_clk50 or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_deb     <= '0;
      r_joy     <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_deb     <= w_deb_next;
      r_joy     <= w_joy_next;
      r_press   <= w_joy_next & ~r_joy;
      r_release <= ~w_joy_next & r_joy;
    end
  end

  assign o_joy     = r_joy;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_changed = |(r_press | r_release);
  assign o_tick    = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_joystick_debounce.sv
// ============================================================================
//  Module      : tb_joystick_debounce
//  Description : Directed bench for joystick_debounce with TICK_DIV=4 and
//                STABLE_CNT=3. Inputs are driven and outputs sampled on the
//                falling clock edge; k counts rising edges since the most
//                recent reset release so expected cycles are written directly.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_joystick_debounce;

  logic       clk;
  logic       rst;
  logic [4:0] joy_n;
  logic [4:0] joy;
  logic [4:0] press;
  logic [4:0] release_s;
  logic       changed;
  logic       tick;

  int errors = 0;
  int checks = 0;
  int k      = 0;
  int pulses = 0;

  joystick_debounce #(
    .N_INPUTS  (5),
    .TICK_DIV  (4),
    .STABLE_CNT(3)
  ) u_dut (
    .i_clk50  (clk),
    .i_rst    (rst),
    .i_joy_n  (joy_n),
    .o_joy    (joy),
    .o_press  (press),
    .o_release(release_s),
    .o_changed(changed),
    .o_tick   (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  // Advance to the falling edge that follows rising edge number 'target'.
  task automatic to_k(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    joy_n = 5'b11111;

    // Reset state.
    @(negedge clk);
    check("rst_joy",     32'(joy),       32'h0);
    check("rst_press",   32'(press),     32'h0);
    check("rst_release", 32'(release_s), 32'h0);
    check("rst_changed", 32'(changed),   32'h0);
    check("rst_tick",    32'(tick),      32'h0);
    @(negedge clk);
    rst = 1'b0;
    k   = 0;

    // Tick cadence: high on cycles 3 and 7 after release.
    for (int n = 1; n <= 8; n++) begin
      to_k(n);
      check("tick_cadence", 32'(tick), (n % 4 == 3) ? 32'h1 : 32'h0);
    end

    // Clean fire press: sample valid from edge 10, ticks 11/15/19, accept at 20.
    joy_n = 5'b01111;
    to_k(19);
    check("press_pre_joy",     32'(joy),     32'h00);
    check("press_pre_changed", 32'(changed), 32'h0);
    to_k(20);
    check("press_joy",     32'(joy),       32'h10);
    check("press_strobe",  32'(press),     32'h10);
    check("press_release", 32'(release_s), 32'h00);
    check("press_changed", 32'(changed),   32'h1);
    to_k(21);
    check("press_one_cycle", 32'(press),   32'h00);
    check("press_chg_off",   32'(changed), 32'h0);

    // Bounce on up: low two tick periods, high one, ten times.
    to_k(24);
    pulses = 0;
    for (int r = 0; r < 10; r++) begin
      joy_n = 5'b01110;
      for (int c = 0; c < 8; c++) begin
        to_k(k + 1);
        if (changed) pulses++;
      end
      joy_n = 5'b01111;
      for (int c = 0; c < 4; c++) begin
        to_k(k + 1);
        if (changed) pulses++;
      end
    end
    check("bounce_pulses", 32'(pulses), 32'h0);
    check("bounce_joy",    32'(joy),    32'h10);

    // Fire release and up press together: k=144, accept at edge 156.
    joy_n = 5'b11110;
    to_k(155);
    check("simul_pre_joy",     32'(joy),     32'h10);
    check("simul_pre_changed", 32'(changed), 32'h0);
    to_k(156);
    check("simul_joy",     32'(joy),       32'h01);
    check("simul_press",   32'(press),     32'h01);
    check("simul_release", 32'(release_s), 32'h10);
    check("simul_changed", 32'(changed),   32'h1);
    to_k(157);
    check("simul_chg_off", 32'(changed), 32'h0);

    // Release up: k=160, accept at edge 172.
    to_k(160);
    joy_n = 5'b11111;
    to_k(172);
    check("rel_joy",     32'(joy),       32'h00);
    check("rel_release", 32'(release_s), 32'h01);

    // Press up, reset after two differing ticks (175, 179).
    joy_n = 5'b11110;
    to_k(181);
    check("midrst_pre_joy", 32'(joy), 32'h00);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_joy",     32'(joy),     32'h00);
    check("midrst_changed", 32'(changed), 32'h0);
    rst = 1'b0;
    k   = 0;
    // Re-sync by edge 2, fresh ticks 3/7/11, accept at 12.
    pulses = 0;
    for (int n = 1; n <= 11; n++) begin
      to_k(n);
      if (joy[0] || changed) pulses++;
    end
    check("midrst_no_early", 32'(pulses), 32'h0);
    to_k(12);
    check("midrst_joy_up",   32'(joy),   32'h01);
    check("midrst_press_up", 32'(press), 32'h01);

    // Opposing directions: add down, accepted at edge 24.
    joy_n = 5'b11100;
    to_k(24);
`ifdef JOY_SOCD_CLEAN_EN
    check("socd_joy",     32'(joy),       32'h00);
    check("socd_release", 32'(release_s), 32'h01);
    check("socd_press",   32'(press),     32'h00);
`else
    check("socd_joy",     32'(joy),       32'h03);
    check("socd_release", 32'(release_s), 32'h00);
    check("socd_press",   32'(press),     32'h02);
`endif
    // Release down, accepted at edge 36.
    joy_n = 5'b11110;
    to_k(35);
`ifdef JOY_SOCD_CLEAN_EN
    check("socd_hold_joy", 32'(joy), 32'h00);
`else
    check("socd_hold_joy", 32'(joy), 32'h03);
`endif
    to_k(36);
    check("socd_up_joy", 32'(joy), 32'h01);
`ifdef JOY_SOCD_CLEAN_EN
    check("socd_up_press",   32'(press),     32'h01);
    check("socd_up_release", 32'(release_s), 32'h00);
`else
    check("socd_up_press",   32'(press),     32'h00);
    check("socd_up_release", 32'(release_s), 32'h02);
`endif
    check("socd_up_changed", 32'(changed), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
